// File: rtl/dmem_responder.sv
// dmem_responder: services CPU load/store requests against one synchronous-read
// block-RAM port with byte write enables. Stores are steered onto byte lanes,
// loads are extracted and sign/zero-extended, and every accepted request gets
// exactly one response over a valid/ready handshake.
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned Lw/Sw/Lh/Lhu/Sh return resp_err=1 without touching the RAM
//   undefined : no misalignment check; halfwords use lane 2*addr[1], words ignore addr[1:0]
module dmem_responder #(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_func,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [3:0] F_LW  = 4'd0;
  localparam logic [3:0] F_LH  = 4'd1;
  localparam logic [3:0] F_LHU = 4'd2;
  localparam logic [3:0] F_LB  = 4'd3;
  localparam logic [3:0] F_LBU = 4'd4;
  localparam logic [3:0] F_SW  = 4'd5;
  localparam logic [3:0] F_SH  = 4'd6;
  localparam logic [3:0] F_SB  = 4'd7;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [3:0]              func_q;
  logic [1:0]              lane_q;
  logic                    mem_en_q, mem_en_d;
  logic [3:0]              mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic [31:0]             resp_data_q, resp_data_d;
  logic                    resp_err_q, resp_err_d;
  logic                    accept;
  logic [1:0]              lane_in;
  logic                    misal_in;
  logic                    unused_addr_bits;

  // Codes 8..15 are all NopM.
  function automatic logic is_nop(input logic [3:0] f);
    return f[3];
  endfunction

  function automatic logic is_store(input logic [3:0] f);
    return (f == F_SW) || (f == F_SH) || (f == F_SB);
  endfunction

  // Byte lane where the access starts; halfwords sit on even lanes, words on lane 0.
  function automatic logic [1:0] access_lane(input logic [3:0] f, input logic [1:0] a);
    case (f)
      F_LB, F_LBU, F_SB: return a;
      F_LH, F_LHU, F_SH: return {a[1], 1'b0};
      default:           return 2'b00;
    endcase
  endfunction

`ifdef DMEM_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [3:0] f, input logic [1:0] a);
    case (f)
      F_LW, F_SW:        return a != 2'b00;
      F_LH, F_LHU, F_SH: return a[0];
      default:           return 1'b0;
    endcase
  endfunction
`endif

  function automatic logic [3:0] store_mask(input logic [3:0] f, input logic [1:0] lane);
    case (f)
      F_SW:    return 4'b1111;
      F_SH:    return 4'b0011 << lane;
      F_SB:    return 4'b0001 << lane;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the store data so whichever lanes are enabled see the right bytes.
  function automatic logic [31:0] store_data(input logic [3:0] f, input logic [31:0] wd);
    case (f)
      F_SW:    return wd;
      F_SH:    return {2{wd[15:0]}};
      F_SB:    return {4{wd[7:0]}};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [3:0] f, input logic [1:0] lane,
                                               input logic [31:0] w);
    logic [31:0] s;
    s = w >> {lane, 3'b000};
    case (f)
      F_LB:    return {{24{s[7]}}, s[7:0]};
      F_LBU:   return {24'd0, s[7:0]};
      F_LH:    return {{16{s[15]}}, s[15:0]};
      F_LHU:   return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction

  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];
  assign lane_in          = access_lane(req_func, req_addr[1:0]);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misal_in         = misaligned(req_func, req_addr[1:0]);
`else
  assign misal_in         = 1'b0;
`endif

  assign req_ready  = (state_q == IDLE) && !rst_in;
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  // Next-state and next-output logic; RAM strobes default low so they only pulse in ISSUE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 4'b0000;
    mem_addr_d  = '0;
    mem_wdata_d = 32'd0;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept      = 1'b1;
          resp_data_d = 32'd0;
          resp_err_d  = 1'b0;
          if (is_nop(req_func)) begin
            state_d = RESP;
          end else if (misal_in) begin
            state_d    = RESP;
            resp_err_d = 1'b1;
          end else begin
            state_d     = ISSUE;
            mem_en_d    = 1'b1;
            mem_addr_d  = req_addr[ADDR_WIDTH+1:2];
            mem_we_d    = store_mask(req_func, lane_in);
            mem_wdata_d = store_data(req_func, req_wdata);
          end
        end
      end
      ISSUE: begin
        if (is_store(func_q)) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = 2'(READ_LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          resp_data_d = load_extract(func_q, lane_q, mem_rdata);
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d     = IDLE;
          resp_data_d = 32'd0;
          resp_err_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset clears everything visible at the ports.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      resp_data_q <= 32'd0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Request context kept for the load extraction after the RAM read returns.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      func_q <= req_func;
      lane_q <= lane_in;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized load/store traffic against a
// byte-addressed reference memory; a behavioural RAM with READ_LATENCY drives mem_rdata.
module tb_dmem_responder;

  localparam int AW    = 12;
  localparam int RL    = 2;
  localparam int WORDS = 1 << AW;
  localparam int BYTES = 4 * WORDS;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          req_valid, req_ready, resp_valid, resp_ready, resp_err, mem_en;
  logic [3:0]    req_func, mem_we;
  logic [31:0]   req_addr, req_wdata, resp_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] ram [WORDS];
  logic [31:0] rp  [RL];
  logic        ram_init;
  logic [7:0]  mbytes [BYTES];

  dmem_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Behavioural block RAM: byte-enabled writes, reads delayed RL cycles.
  always @(posedge clk_in) begin
    if (ram_init) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
    end else if (mem_en) begin
      for (int l = 0; l < 4; l++)
        if (mem_we[l]) ram[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
    end
    rp[0] <= ram[mem_addr];
    for (int i = 1; i < RL; i++) rp[i] <= rp[i-1];
  end
  assign mem_rdata = rp[RL-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: what one request should do, derived from byte-addressed memory semantics.
  function automatic void model_exec(input logic [3:0] f, input logic [31:0] a,
                                     input logic [31:0] wd,
                                     output logic [31:0] d, output logic e, output bit acc,
                                     output logic [3:0] we, output logic [31:0] wl,
                                     output int lat, output logic [AW-1:0] widx);
    int unsigned ea, size, v;
    ea = a % BYTES;
    d = 0; e = 0; acc = 0; we = 0; wl = 0; lat = 1; widx = 0;
    case (f)
      4'd0, 4'd5:       size = 4;
      4'd1, 4'd2, 4'd6: size = 2;
      4'd3, 4'd4, 4'd7: size = 1;
      default:          size = 0;
    endcase
    if (size == 0) return;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (ea % size != 0) begin
      e = 1;
      return;
    end
`else
    ea = ea - ea % size;
`endif
    acc  = 1;
    widx = AW'(ea / 4);
    if (f >= 4'd5) begin
      for (int j = 0; j < int'(size); j++) begin
        mbytes[ea + j]            = wd[8*j +: 8];
        we[(ea % 4) + j]          = 1'b1;
        wl[8*((ea % 4) + j) +: 8] = wd[8*j +: 8];
      end
      lat = 2;
    end else begin
      v = 0;
      for (int j = 0; j < int'(size); j++) v = v | (32'(mbytes[ea + j]) << (8*j));
      if (f == 4'd1 && v >= 32768) v = v + 32'hFFFF0000;
      if (f == 4'd3 && v >= 128)   v = v + 32'hFFFFFF00;
      d   = v;
      lat = 2 + RL;
    end
  endfunction

  // One complete transaction: called and returns at a negedge.
  task automatic do_req(input logic [3:0] f, input logic [31:0] a, input logic [31:0] wd,
                        input int stall, output logic [31:0] got_d, output logic got_e);
    logic [31:0]   ed, ewl, mask, seen_wd;
    logic          ee;
    bit            acc;
    logic [3:0]    ewe, seen_we;
    logic [AW-1:0] eidx, seen_idx;
    int            elat, cyc, ens, bad;
    model_exec(f, a, wd, ed, ee, acc, ewe, ewl, elat, eidx);
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(negedge clk_in);
      cyc++;
    end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_func = f; req_addr = a; req_wdata = wd;
    @(posedge clk_in);
    @(negedge clk_in);
    req_valid = 1'b0;
    req_func = 4'($urandom); req_addr = $urandom; req_wdata = $urandom;
    cyc = 1; ens = 0; bad = 0; seen_we = 0; seen_idx = 0; seen_wd = 0;
    while (!resp_valid && cyc < 20) begin
      if (mem_en) begin
        ens++; seen_we = mem_we; seen_idx = mem_addr; seen_wd = mem_wdata;
      end else if (mem_we != 4'b0000) bad++;
      if (req_ready) bad++;
      @(negedge clk_in);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(elat));
    check("mem_en_pulses", 32'(ens), acc ? 32'd1 : 32'd0);
    check("strobes_in_resp", {28'd0, mem_en, mem_we[2:0] | {2'b00, mem_we[3]}}, 32'd0);
    check("busy_flags", 32'(bad), 32'd0);
    if (acc) begin
      mask = 0;
      for (int l = 0; l < 4; l++) if (ewe[l]) mask[8*l +: 8] = 8'hFF;
      check("mem_addr", 32'(seen_idx), 32'(eidx));
      check("mem_we", 32'(seen_we), 32'(ewe));
      check("mem_wdata", seen_wd & mask, ewl);
    end
    got_d = resp_data;
    got_e = resp_err;
    for (int s = 0; s < stall; s++) begin
      resp_ready = 1'b0;
      @(negedge clk_in);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_data", resp_data, got_d);
      check("hold_err", 32'(resp_err), 32'(got_e));
      check("hold_busy", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    resp_ready = 1'b0;
    check("resp_done", {30'd0, resp_valid, req_ready}, 32'd1);
    check("resp_data", got_d, ed);
    check("resp_err", 32'(got_e), 32'(ee));
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {26'd0, req_ready, resp_valid, resp_err, mem_en, 2'b00}, 32'd0);
    check({tag, "_data"}, resp_data | mem_wdata | 32'(mem_we) | 32'(mem_addr), 32'd0);
  endtask

  logic [31:0] d;
  logic        e;
  logic [3:0]  rf;
  logic [31:0] ra;
  int          seen;

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      logic [31:0] w;
      w = init_word(i);
      for (int j = 0; j < 4; j++) mbytes[4*i + j] = w[8*j +: 8];
    end
    rst_in = 1'b1; ram_init = 1'b1;
    req_valid = 1'b0; req_func = 4'd8; req_addr = 0; req_wdata = 0; resp_ready = 1'b0;
    repeat (3) @(negedge clk_in);
    ram_init = 1'b0;
    check_all_zero("reset_state");
    rst_in = 1'b0;
    @(negedge clk_in);

    // Word store then load back.
    do_req(4'd5, 32'h10, 32'hDEADBEEF, 0, d, e);
    do_req(4'd0, 32'h10, 32'h0, 0, d, e);
    check("lw_deadbeef", d, 32'hDEADBEEF);

    // Byte store into lane 3, then signed/unsigned byte loads.
    do_req(4'd5, 32'h10, 32'h11223344, 0, d, e);
    do_req(4'd7, 32'h13, 32'h000000F0, 0, d, e);
    do_req(4'd0, 32'h10, 32'h0, 0, d, e);
    check("sb_word", d, 32'hF0223344);
    do_req(4'd3, 32'h13, 32'h0, 0, d, e);
    check("lb_sext", d, 32'hFFFFFFF0);
    do_req(4'd4, 32'h13, 32'h0, 0, d, e);
    check("lbu_zext", d, 32'h000000F0);

    // Upper halfword store and loads.
    do_req(4'd6, 32'h22, 32'h00008001, 0, d, e);
    do_req(4'd1, 32'h22, 32'h0, 0, d, e);
    check("lh_sext", d, 32'hFFFF8001);
    do_req(4'd2, 32'h22, 32'h0, 0, d, e);
    check("lhu_zext", d, 32'h00008001);

    // Misaligned word load.
    do_req(4'd0, 32'h102, 32'h0, 0, d, e);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("misal_err", {31'd0, e}, 32'd1);
`else
    check("misal_word", d, init_word(32'h100 / 4));
`endif

    // Backpressure: response held for 5 cycles.
    do_req(4'd0, 32'h10, 32'h0, 5, d, e);
    check("stall_lw", d, 32'hF0223344);

    // Randomized traffic over a small window with wrapping high address bits.
    for (int n = 0; n < 150; n++) begin
      rf = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 8));
      ra = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 63));
      do_req(rf, ra, $urandom, int'($urandom_range(0, 2)), d, e);
    end

    // Reset while a load is waiting on the RAM.
    check("rst_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_func = 4'd0; req_addr = 32'h40; req_wdata = 0;
    @(posedge clk_in);
    @(negedge clk_in);
    req_valid = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check_all_zero("reset_in_wait");
    rst_in = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      if (resp_valid) seen++;
    end
    check("no_resp_after_reset", 32'(seen), 32'd0);
    do_req(4'd8, 32'h0, 32'h0, 0, d, e);
    check("nop_data", d, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
